// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port write-back arbiter for the register file write port
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of all queued and staged writes
//   req0_* / req1_*     valid/ready write requests {addr, data}; port 0 = ALU, port 1 = load/multi-cycle
//   rf_wr/rf_addr/rf_data  registered register-file write port
//   pend_mask           one bit per register with a queued or staged write (bit 0 always 0)
//   busy                any FIFO non-empty or rf_wr high
`timescale 1ns/1ps

module regfile_wb_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              rf_wr,
  output logic [4:0]        rf_addr,
  output logic [DWIDTH-1:0] rf_data,
  output logic [31:0]       pend_mask,
  output logic              busy
);

  // Per-port 2-entry FIFO, kept as a shift queue: slot 0 is always the head.
  logic [1:0]        cnt_q      [2];
  logic [1:0]        cnt_d      [2];
  logic [4:0]        ent_addr_q [2][2];
  logic [4:0]        ent_addr_d [2][2];
  logic [DWIDTH-1:0] ent_data_q [2][2];
  logic [DWIDTH-1:0] ent_data_d [2][2];

  // rr_last_q = 1 means port 1 was granted last, so port 0 wins the next tie.
  logic              rr_last_q, rr_last_d;
  logic              rf_wr_q, rf_wr_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [DWIDTH-1:0] rf_data_q, rf_data_d;

  logic [1:0]        in_valid;
  logic [4:0]        in_addr [2];
  logic [DWIDTH-1:0] in_data [2];
  logic [1:0]        head_valid;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        grant;
  logic [4:0]        gnt_addr;
  logic [DWIDTH-1:0] gnt_data;
  logic [31:0]       pend;

  assign in_valid   = {req1_valid, req0_valid};
  assign in_addr[0] = req0_addr;
  assign in_addr[1] = req1_addr;
  assign in_data[0] = req0_data;
  assign in_data[1] = req1_data;

  always_comb begin : arb
    for (int p = 0; p < 2; p++) begin
      head_valid[p] = (cnt_q[p] != 2'd0);
      // Ready comes from registered occupancy only: a full FIFO never
      // accepts, even on an edge where it is popped.
      ready[p]      = (cnt_q[p] != 2'd2);
      push[p]       = in_valid[p] & ready[p];
    end
    grant[0] = head_valid[0] & (~head_valid[1] | rr_last_q);
    grant[1] = head_valid[1] & (~head_valid[0] | ~rr_last_q);
    gnt_addr = grant[1] ? ent_addr_q[1][0] : ent_addr_q[0][0];
    gnt_data = grant[1] ? ent_data_q[1][0] : ent_data_q[0][0];
  end

  always_comb begin : fifo_next
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 2; s++) begin
        ent_addr_d[p][s] = ent_addr_q[p][s];
        ent_data_d[p][s] = ent_data_q[p][s];
      end
      cnt_d[p] = cnt_q[p];
      if (flush) begin
        cnt_d[p] = 2'd0;
      end else begin
        if (grant[p]) begin
          ent_addr_d[p][0] = ent_addr_q[p][1];
          ent_data_d[p][0] = ent_data_q[p][1];
        end
        if (push[p]) begin
          // The new entry lands just behind whatever survives this edge's pop.
          if (cnt_q[p][0] & ~grant[p]) begin
            ent_addr_d[p][1] = in_addr[p];
            ent_data_d[p][1] = in_data[p];
          end else begin
            ent_addr_d[p][0] = in_addr[p];
            ent_data_d[p][0] = in_data[p];
          end
        end
        cnt_d[p] = cnt_q[p] + {1'b0, push[p]} - {1'b0, grant[p]};
      end
    end
  end

  always_comb begin : out_next
    rr_last_d = rr_last_q;
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (!flush && (grant != 2'b00)) begin
      rr_last_d = grant[1];
      // x0 entries are popped but never presented to the register file.
      if (gnt_addr != 5'd0) begin
        rf_wr_d   = 1'b1;
        rf_addr_d = gnt_addr;
        rf_data_d = gnt_data;
      end
    end
  end

  always_comb begin : pend_calc
    pend = 32'd0;
    for (int p = 0; p < 2; p++) begin
      if (cnt_q[p] != 2'd0) pend[ent_addr_q[p][0]] = 1'b1;
      if (cnt_q[p][1])      pend[ent_addr_q[p][1]] = 1'b1;
    end
    if (rf_wr_q) pend[rf_addr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p] <= 2'd0;
        for (int s = 0; s < 2; s++) begin
          ent_addr_q[p][s] <= 5'd0;
          ent_data_q[p][s] <= '0;
        end
      end
      rr_last_q <= 1'b1;
      rf_wr_q   <= 1'b0;
      rf_addr_q <= 5'd0;
      rf_data_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        cnt_q[p] <= cnt_d[p];
        for (int s = 0; s < 2; s++) begin
          ent_addr_q[p][s] <= ent_addr_d[p][s];
          ent_data_q[p][s] <= ent_data_d[p][s];
        end
      end
      rr_last_q <= rr_last_d;
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign rf_wr      = rf_wr_q;
  assign rf_addr    = rf_addr_q;
  assign rf_data    = rf_data_q;
  assign pend_mask  = pend;
  assign busy       = head_valid[0] | head_valid[1] | rf_wr_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]    req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          rf_wr;
  logic [4:0]    rf_addr;
  logic [DW-1:0] rf_data;
  logic [31:0]   pend_mask;
  logic          busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data), .pend_mask(pend_mask), .busy(busy)
  );

  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq0[$];
  ent_t          mq1[$];
  logic          m_rr, m_wr;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rf_mem [32];
  logic [4:0]    wr_log[$];

  int total = 0;
  int bad = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queues per port, round-robin pointer, one output register.
  always @(posedge clk or negedge rst_n) begin : model
    ent_t h;
    int   g;
    bit   r0, r1;
    if (!rst_n) begin
      mq0.delete(); mq1.delete();
      m_rr = 1'b1; m_wr = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      r0 = mq0.size() < 2;
      r1 = mq1.size() < 2;
      if (flush) begin
        mq0.delete(); mq1.delete();
        m_wr = 1'b0;
      end else begin
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = m_rr ? 0 : 1;
        else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        m_wr = 1'b0;
        if (g >= 0) begin
          h = (g == 0) ? mq0.pop_front() : mq1.pop_front();
          m_rr = (g == 1);
          if (h.a != 5'd0) begin
            m_wr = 1'b1; m_addr = h.a; m_data = h.d;
          end
        end
        if (req0_valid && r0) mq0.push_back({req0_addr, req0_data});
        if (req1_valid && r1) mq1.push_back({req1_addr, req1_data});
      end
    end
  end

  function automatic logic [31:0] model_pend();
    logic [31:0] p = 32'd0;
    foreach (mq0[i]) p[mq0[i].a] = 1'b1;
    foreach (mq1[i]) p[mq1[i].a] = 1'b1;
    if (m_wr) p[m_addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Register file model captures on the falling edge; outputs compared there too.
  always @(negedge clk) begin
    if (rf_wr === 1'b1) begin
      rf_mem[rf_addr] = rf_data;
      wr_log.push_back(rf_addr);
    end
    if (cmp_en && rst_n) begin
      chk("ready0", req0_ready, mq0.size() < 2);
      chk("ready1", req1_ready, mq1.size() < 2);
      chk("rf_wr", rf_wr, m_wr);
      chk("rf_addr", rf_addr, m_addr);
      chk("rf_data", rf_data, m_data);
      chk("pend_mask", pend_mask, model_pend());
      chk("busy", busy, (mq0.size() != 0) || (mq1.size() != 0) || m_wr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  logic [4:0] a0l [3];
  logic [4:0] a1l [3];
  logic [4:0] exp_order [6];
  int  i0, i1;
  bit  acc0, acc1, saw_full0, saw_full1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    a0l = '{5'd1, 5'd2, 5'd3};
    a1l = '{5'd9, 5'd10, 5'd11};
    exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    rst_n = 1'b0; flush = 1'b0;
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    #3;
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_data", rf_data, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);
    chk("rst_pend", pend_mask, 0);
    chk("rst_busy", busy, 0);
    #9;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: single write
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    tick();
    req0_valid = 0;
    chk("t1_pend_e1", pend_mask, 32'h20);
    chk("t1_wr_e1", rf_wr, 0);
    tick();
    chk("t1_wr_e2", rf_wr, 1);
    chk("t1_addr_e2", rf_addr, 5);
    chk("t1_data_e2", rf_data, 32'hDEADBEEF);
    chk("t1_pend_e2", pend_mask, 32'h20);
    tick();
    chk("t1_wr_e3", rf_wr, 0);
    chk("t1_pend_e3", pend_mask, 0);
    chk("t1_rfmem", rf_mem[5], 32'hDEADBEEF);

    // 2: contention
    tick();
    reset_dut();
    wr_log.delete();
    i0 = 0; i1 = 0; saw_full0 = 0; saw_full1 = 0;
    for (int c = 0; c < 30 && (i0 < 3 || i1 < 3); c++) begin
      req0_valid = (i0 < 3);
      if (i0 < 3) begin req0_addr = a0l[i0]; req0_data = 32'h100 + i0; end
      req1_valid = (i1 < 3);
      if (i1 < 3) begin req1_addr = a1l[i1]; req1_data = 32'h200 + i1; end
      if (!req0_ready) saw_full0 = 1;
      if (!req1_ready) saw_full1 = 1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      if (acc0) i0++;
      if (acc1) i1++;
    end
    req0_valid = 0; req1_valid = 0;
    chk("t2_all_sent", i0 + i1, 6);
    wait_idle("t2_idle");
    chk("t2_log_len", wr_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < wr_log.size()) chk($sformatf("t2_order%0d", k), wr_log[k], exp_order[k]);
    chk("t2_full0_seen", saw_full0, 1);
    chk("t2_full1_seen", saw_full1, 1);

    // 3: x0 discard
    req1_valid = 1; req1_addr = 5'd0; req1_data = 32'h1234;
    tick();
    req1_valid = 0;
    chk("t3_busy_e1", busy, 1);
    chk("t3_pend_e1", pend_mask, 0);
    chk("t3_wr_e1", rf_wr, 0);
    tick();
    chk("t3_busy_e2", busy, 0);
    chk("t3_wr_e2", rf_wr, 0);
    chk("t3_pend_e2", pend_mask, 0);

    // 4: full port 0, push attempted on the edge it is popped
    reset_dut();
    req0_valid = 1; req0_addr = 5'd4; req0_data = 32'hA4;
    tick();
    req0_addr = 5'd5; req0_data = 32'hA5;
    req1_valid = 1; req1_addr = 5'd12; req1_data = 32'hBC;
    tick();
    req1_valid = 0;
    req0_addr = 5'd6; req0_data = 32'hA6;
    tick();
    req0_addr = 5'd7; req0_data = 32'hA7;
    chk("t4_ready0_full", req0_ready, 0);
    chk("t4_out_c", rf_addr, 12);
    tick();
    chk("t4_ready0_back", req0_ready, 1);
    chk("t4_wr", rf_wr, 1);
    chk("t4_addr", rf_addr, 5);
    chk("t4_pend", pend_mask, 32'h60);
    tick();
    req0_valid = 0;
    wait_idle("t4_idle");

    // 5: flush
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1; req1_addr = 5'd4; req1_data = 32'h44;
    tick();
    req0_addr = 5'd5; req0_data = 32'h55;
    req1_addr = 5'd6; req1_data = 32'h66;
    tick();
    chk("t5_wr_before", rf_wr, 1);
    chk("t5_busy_before", busy, 1);
    if (req0_ready) begin req0_addr = 5'd9; req0_data = 32'h99; end
    if (req1_ready) begin req1_addr = 5'd8; req1_data = 32'h88; end
    flush = 1;
    tick();
    flush = 0; req0_valid = 0; req1_valid = 0;
    chk("t5_wr", rf_wr, 0);
    chk("t5_pend", pend_mask, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready0", req0_ready, 1);
    tick();
    chk("t5_dropped", busy, 0);

    // 6: asynchronous reset mid-burst
    req0_valid = 1; req0_addr = 5'd14; req0_data = 32'hE0;
    req1_valid = 1; req1_addr = 5'd15; req1_data = 32'hF0;
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t6_wr_before", rf_wr, 1);
    rst_n = 0;
    #1;
    chk("t6_wr", rf_wr, 0);
    chk("t6_pend", pend_mask, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready1", req1_ready, 1);
    #3;
    rst_n = 1;
    req0_valid = 1; req0_addr = 5'd20; req0_data = 32'h20;
    req1_valid = 1; req1_addr = 5'd21; req1_data = 32'h21;
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t6_tie_p0", rf_addr, 20);
    chk("t6_tie_wr", rf_wr, 1);
    tick();
    chk("t6_tie_p1", rf_addr, 21);

    // random phase, checked by the model every cycle
    for (int c = 0; c < 2000; c++) begin
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      tick();
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = 5'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = 5'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
    end
    flush = 0; req0_valid = 0; req1_valid = 0;
    wait_idle("rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
